fetch_prefetch: RTL and testbench

FETCH_PREFETCH -- requirements
Module: fetch_prefetch

---
 rtl/fetch_prefetch_if.sv | 45 ++++
 rtl/fetch_prefetch.sv | 107 ++++++++++
 tb/tb_fetch_prefetch.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_if.sv
// Fetch-side bundle: instruction memory request/response, redirect and decode handoff.
// The master modport is the prefetch unit; the slave side is memory plus decode.
interface fetch_prefetch_if #(
    parameter int unsigned XLEN = 32
);
    logic            mem_req_o;
    logic [XLEN-1:0] mem_addr_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [31:0]     mem_rdata_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            instr_valid_o;
    logic [31:0]     instr_o;
    logic [XLEN-1:0] instr_pc_o;
    logic            instr_ready_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_gnt_i,
        input  mem_rvalid_i,
        input  mem_rdata_i,
        input  redirect_i,
        input  redirect_pc_i,
        output instr_valid_o,
        output instr_o,
        output instr_pc_o,
        input  instr_ready_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_gnt_i,
        output mem_rvalid_i,
        output mem_rdata_i,
        output redirect_i,
        output redirect_pc_i,
        input  instr_valid_o,
        input  instr_o,
        input  instr_pc_o,
        output instr_ready_i
    );
endinterface

// File: rtl/fetch_prefetch.sv
// Instruction prefetch buffer: issues word fetches ahead of decode and
// silently drops responses that belong to fetches made before a redirect.
module fetch_prefetch #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input logic              clk_i,
    input logic              rst_i,
    fetch_prefetch_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0]     word;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t          fifo_q [DEPTH];
    logic [XLEN-1:0] fpc_q;
    logic [XLEN-1:0] rpc_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   out_q;
    logic [CW-1:0]   disc_q;
    logic [CW-1:0]   out_d;
    logic [PW-1:0]   wptr_q;
    logic [PW-1:0]   rptr_q;
    logic [CW:0]     inflight;
    logic [XLEN-1:0] redir_pc;
    logic            head_vld;
    logic            grant;
    logic            rsp;
    logic            push;
    logic            pop;
    logic            redir;

    // Every granted fetch reserves a slot, so the buffer cannot overflow.
    assign inflight = {1'b0, out_q} + {1'b0, cnt_q};
    assign bus.mem_req_o  = inflight < DEPTH_W;
    assign bus.mem_addr_o = fpc_q;

    assign redir    = bus.redirect_i;
    assign redir_pc = {bus.redirect_pc_i[XLEN-1:2], 2'b00};
    assign head_vld = cnt_q != '0;

    assign grant = bus.mem_req_o & bus.mem_gnt_i;
    assign rsp   = bus.mem_rvalid_i & (out_q != '0);
    assign push  = rsp & ~redir & (disc_q == '0);
    assign pop   = head_vld & bus.instr_ready_i & ~redir;
    assign out_d = out_q + CW'(grant) - CW'(rsp);

    assign bus.instr_valid_o = head_vld;
    assign bus.instr_o    = head_vld ? fifo_q[rptr_q].word : 32'h0;
    assign bus.instr_pc_o = head_vld ? fifo_q[rptr_q].pc : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fpc_q <= RESET_PC;
        end else if (redir) begin
            fpc_q <= redir_pc;
        end else if (grant) begin
            fpc_q <= fpc_q + XLEN'(4);
        end
    end

    // On redirect everything still in flight is stale, including this
    // cycle's grant; this cycle's response is already retired by out_d.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q  <= '0;
            disc_q <= '0;
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            rpc_q  <= RESET_PC;
        end else begin
            out_q <= out_d;
            if (redir) begin
                disc_q <= out_d;
                cnt_q  <= '0;
                wptr_q <= '0;
                rptr_q <= '0;
                rpc_q  <= redir_pc;
            end else begin
                if (rsp && disc_q != '0) begin
                    disc_q <= disc_q - CW'(1);
                end
                if (push) begin
                    wptr_q <= wptr_q + PW'(1);
                    rpc_q  <= rpc_q + XLEN'(4);
                end
                if (pop) begin
                    rptr_q <= rptr_q + PW'(1);
                end
                cnt_q <= cnt_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wptr_q] <= '{word: bus.mem_rdata_i, pc: rpc_q};
        end
    end
endmodule

// File: tb/tb_fetch_prefetch.sv
// Randomized bench for fetch_prefetch against an epoch-tagged memory/decode model.
module tb_fetch_prefetch;
    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } pend_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    fetch_prefetch_if #(.XLEN(32)) bus ();

    fetch_prefetch #(
        .XLEN(32),
        .DEPTH(DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus(bus)
    );

    always #5 clk_i = ~clk_i;

    pend_t       pend[$];
    logic [31:0] kept[$];
    logic [31:0] fpc;
    int          epoch;
    int          n_grant;
    int          n_vec;
    int          n_err;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
    endfunction

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.mem_gnt_i     = 1'b0;
        bus.mem_rvalid_i  = 1'b0;
        bus.mem_rdata_i   = 32'h0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.instr_ready_i = 1'b0;
    endtask

    task automatic model_clear();
        pend.delete();
        kept.delete();
        fpc = RESET_PC;
        epoch++;
    endtask

    // One clock: check outputs, drive inputs, advance the model, cross the edge.
    task automatic step(input bit gnt, input bit rv, input bit rdy,
                        input bit redir, input logic [31:0] tgt,
                        input bit stray);
        pend_t e;
        bit    mreq;
        bit    grant;
        bit    rsp;
        bit    pop;
        mreq = (pend.size() + kept.size()) < DEPTH;
        check("valid", bus.instr_valid_o, kept.size() != 0);
        if (kept.size() != 0) begin
            check("pc", bus.instr_pc_o, kept[0]);
            check("instr", bus.instr_o, mem_word(kept[0]));
        end
        check("req", bus.mem_req_o, mreq);
        if (mreq) check("addr", bus.mem_addr_o, fpc);
        rsp = rv && pend.size() != 0;
        bus.mem_gnt_i     = gnt;
        bus.mem_rvalid_i  = rsp || (stray && pend.size() == 0);
        bus.mem_rdata_i   = rsp ? mem_word(pend[0].addr) : $urandom;
        bus.instr_ready_i = rdy;
        bus.redirect_i    = redir;
        bus.redirect_pc_i = tgt;
        grant = mreq && gnt;
        pop = kept.size() != 0 && rdy && !redir;
        if (pop) void'(kept.pop_front());
        if (rsp) begin
            e = pend.pop_front();
            if (!redir && e.epoch == epoch) kept.push_back(e.addr);
        end
        if (grant) begin
            e.addr  = fpc;
            e.epoch = epoch;
            pend.push_back(e);
            n_grant++;
            fpc = fpc + 32'd4;
        end
        if (redir) begin
            kept.delete();
            epoch++;
            fpc = tgt & ~32'h3;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        idle_inputs();
        model_clear();
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_valid", bus.instr_valid_o, 1'b0);
        check("rst_instr", bus.instr_o, 32'h0);
        check("rst_pc", bus.instr_pc_o, 32'h0);
        check("rst_addr", bus.mem_addr_o, RESET_PC);
        rst_i = 1'b0;
        #1;
        check("rst_req", bus.mem_req_o, 1'b1);
    endtask

    initial begin
        int g0;
        int pg;
        int pr;
        int py;
        bit red;
        logic [31:0] tgt;
        n_vec = 0;
        n_err = 0;
        n_grant = 0;
        epoch = 0;
        idle_inputs();
        do_reset();

        for (int i = 0; i < 40; i++) begin
            if (i >= 2) check("stream_gap", bus.instr_valid_o, 1'b1);
            if (i >= 2) check("stream_pc", bus.instr_pc_o, 32'(4 * (i - 2)));
            step(1, 1, 1, 0, 0, 0);
        end

        do_reset();
        g0 = n_grant;
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0, 0);
        check("full_grants", 32'(n_grant - g0), 32'd4);
        check("full_req", bus.mem_req_o, 1'b0);
        g0 = n_grant;
        step(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0, 0);
        check("one_pop_grant", 32'(n_grant - g0), 32'd1);

        do_reset();
        step(0, 0, 1, 1, 32'h10, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 32'h103, 0);
        check("redir_addr", bus.mem_addr_o, 32'h100);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        check("stale_drop", bus.instr_valid_o, 1'b0);
        for (int i = 0; i < 6 && !bus.instr_valid_o; i++) step(1, 1, 1, 0, 0, 0);
        check("redir_first_pc", bus.instr_pc_o, 32'h100);
        for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 0, 0);

        do_reset();
        step(1, 0, 1, 0, 0, 0);
        step(1, 1, 1, 1, 32'h40, 0);
        for (int i = 0; i < 6 && !bus.instr_valid_o; i++) step(1, 1, 1, 0, 0, 0);
        check("same_cyc_pc", bus.instr_pc_o, 32'h40);
        for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 0, 0);

        do_reset();
        step(0, 0, 1, 1, 32'hFFFF_FFFC, 0);
        step(1, 1, 1, 0, 0, 0);
        check("wrap_addr", bus.mem_addr_o, 32'h0);
        for (int i = 0; i < 6 && !bus.instr_valid_o; i++) step(1, 1, 1, 0, 0, 0);
        check("wrap_pc_hi", bus.instr_pc_o, 32'hFFFF_FFFC);
        step(1, 1, 1, 0, 0, 0);
        check("wrap_pc_lo", bus.instr_pc_o, 32'h0);
        for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
        check("pre_rst_valid", bus.instr_valid_o, 1'b1);
        check("pre_rst_req", bus.mem_req_o, 1'b0);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_valid", bus.instr_valid_o, 1'b0);
        check("async_instr", bus.instr_o, 32'h0);
        check("async_pc", bus.instr_pc_o, 32'h0);
        check("async_addr", bus.mem_addr_o, RESET_PC);
        idle_inputs();
        model_clear();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        step(0, 0, 1, 0, 0, 1);
        check("stray_ignored", bus.instr_valid_o, 1'b0);
        for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 0, 0);

        for (int blk = 0; blk < 6; blk++) begin
            pg = $urandom_range(30, 100);
            pr = $urandom_range(30, 100);
            py = $urandom_range(20, 100);
            for (int i = 0; i < 500; i++) begin
                red = $urandom_range(0, 99) < 4;
                if ($urandom_range(0, 3) == 0)
                    tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                else
                    tgt = $urandom;
                step($urandom_range(0, 99) < pg, $urandom_range(0, 99) < pr,
                     $urandom_range(0, 99) < py, red, tgt,
                     $urandom_range(0, 9) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
